// File: rtl/prbs_addr_gen_mc.sv
// Multi-channel PRBS/sequential address generator, round-robin over NUM_CH LFSRs; `PRBS_LOCKUP_RECOVER_EN adds zero-state recovery.
// Latency: seed_load_i in N -> LOAD in N+1 -> first address valid in N+2; then one address per handshake.
// Backpressure: addr_o/ch_o hold while addr_vld_o=1 and addr_rdy_i=0; reseed discards a coincident handshake.
module prbs_addr_gen_mc #(
    parameter int          TCQ        = 100,
    parameter int          NUM_CH     = 4,
    parameter int          PRBS_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter int          DWIDTH     = 32,
    parameter logic [63:0] TAPS       = 64'h8020_0003,
    parameter logic [63:0] SADDR      = 64'h0000_0000,
    parameter logic [63:0] SPAN_MASK  = 64'h00FF_FFFF,
    localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  seed_load_i,
    input  logic [PRBS_WIDTH-1:0] seed_i,
    input  logic                  mode_i,
    input  logic                  addr_rdy_i,
    output logic                  addr_vld_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [CH_W-1:0]       ch_o
`ifdef PRBS_LOCKUP_RECOVER_EN
    ,
    output logic [15:0]           lockup_cnt_o
`endif
);

    if (NUM_CH < 1 || NUM_CH > 16 || PRBS_WIDTH < 8 || PRBS_WIDTH > 64 ||
        PRBS_WIDTH < ADDR_WIDTH || DWIDTH < 8 || TCQ < 0) begin : g_param_check
        $error("prbs_addr_gen_mc: illegal parameter combination");
    end

    localparam logic [PRBS_WIDTH-1:0] TAPS_W = TAPS[PRBS_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] SPAN_W = SPAN_MASK[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] BASE   = SADDR[ADDR_WIDTH-1:0] & ~SPAN_W;
    localparam logic [ADDR_WIDTH-1:0] ALIGN  = ADDR_WIDTH'(DWIDTH / 8 - 1);
    localparam logic [ADDR_WIDTH-1:0] KEEP   = SPAN_W & ~ALIGN;
    localparam logic [PRBS_WIDTH-1:0] STEP   = PRBS_WIDTH'(DWIDTH / 8);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t                  state_q;
    logic                    mode_q;
    logic                    vld_q;
    logic [CH_W-1:0]         ch_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [PRBS_WIDTH-1:0]   lfsr_q [NUM_CH];

    // Per-channel salt keeps the channels decorrelated from a single seed.
    function automatic logic [PRBS_WIDTH-1:0] seed_for(input logic [PRBS_WIDTH-1:0] base, input int k);
        logic [31:0]           salt32;
        logic [63:0]           salt64;
        logic [PRBS_WIDTH-1:0] s;
        salt32 = 32'(k) * 32'h9E37_79B9;
        salt64 = {32'd0, salt32};
        s      = base ^ salt64[PRBS_WIDTH-1:0];
        return (s == '0) ? PRBS_WIDTH'(1) : s;
    endfunction

    function automatic logic [PRBS_WIDTH-1:0] next_state(input logic [PRBS_WIDTH-1:0] s, input logic seq);
        return seq ? s + STEP : {s[PRBS_WIDTH-2:0], ^(s & TAPS_W)};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] to_addr(input logic [PRBS_WIDTH-1:0] s);
        return BASE | (s[ADDR_WIDTH-1:0] & KEEP);
    endfunction

    logic                  hs;
    logic                  lockup;
    logic [NUM_CH-1:0]     zero_ch;
    logic [CH_W-1:0]       ch_nxt;
    logic [PRBS_WIDTH-1:0] stepped;
    logic [PRBS_WIDTH-1:0] nxt_sel;

`ifdef PRBS_LOCKUP_RECOVER_EN
    always_comb begin
        zero_ch = '0;
        for (int k = 0; k < NUM_CH; k++)
            zero_ch[k] = (state_q == S_RUN) && !mode_q && (lfsr_q[k] == '0);
    end
`else
    assign zero_ch = '0;
`endif

    assign lockup     = |zero_ch;
    assign addr_vld_o = vld_q & ~lockup;
    assign addr_o     = addr_q;
    assign ch_o       = ch_q;
    assign hs         = addr_vld_o & addr_rdy_i;
    assign ch_nxt     = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
    assign stepped    = next_state(lfsr_q[ch_q], mode_q);
    // With a single channel the next address comes from the freshly stepped state.
    assign nxt_sel    = (ch_nxt == ch_q) ? stepped : lfsr_q[ch_nxt];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            vld_q   <= 1'b0;
            ch_q    <= '0;
            addr_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) lfsr_q[k] <= '0;
`ifdef PRBS_LOCKUP_RECOVER_EN
            lockup_cnt_o <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (seed_load_i) begin
                        state_q <= S_LOAD;
                        for (int k = 0; k < NUM_CH; k++) lfsr_q[k] <= seed_for(seed_i, k);
                    end
                end
                S_LOAD: begin
                    state_q <= S_RUN;
                    mode_q  <= mode_i;
                    vld_q   <= 1'b1;
                    ch_q    <= '0;
                    addr_q  <= to_addr(lfsr_q[0]);
                end
                S_RUN: begin
                    if (seed_load_i) begin
                        state_q <= S_LOAD;
                        vld_q   <= 1'b0;
                        ch_q    <= '0;
                        for (int k = 0; k < NUM_CH; k++) lfsr_q[k] <= seed_for(seed_i, k);
                    end else if (lockup) begin
                        for (int k = 0; k < NUM_CH; k++)
                            if (zero_ch[k]) lfsr_q[k] <= PRBS_WIDTH'(1);
                        addr_q <= to_addr(zero_ch[ch_q] ? PRBS_WIDTH'(1) : lfsr_q[ch_q]);
`ifdef PRBS_LOCKUP_RECOVER_EN
                        if (lockup_cnt_o != 16'hFFFF) lockup_cnt_o <= lockup_cnt_o + 16'd1;
`endif
                    end else if (hs) begin
                        lfsr_q[ch_q] <= stepped;
                        ch_q         <= ch_nxt;
                        addr_q       <= to_addr(nxt_sel);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_addr_gen_mc.sv
// Scoreboard bench for prbs_addr_gen_mc: default 4-channel instance plus an 8-bit single-channel instance.
module tb_prbs_addr_gen_mc;

    localparam logic [31:0] M_TAPS = 32'h8020_0003;
    localparam logic [31:0] M_SPAN = 32'h00FF_FFFF;
    localparam logic [31:0] M_BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [31:0] seed = '0;
    logic        mode = 1'b0;
    logic        rdy = 1'b0;
    logic        vld;
    logic [31:0] addr;
    logic [1:0]  ch;

    logic        seed_load8 = 1'b0;
    logic [7:0]  seed8 = '0;
    logic        mode8 = 1'b0;
    logic        rdy8 = 1'b0;
    logic        vld8;
    logic [7:0]  addr8;
    logic        ch8;

`ifdef PRBS_LOCKUP_RECOVER_EN
    logic [15:0] lockup_cnt;
    logic [15:0] lockup_cnt8;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] addr;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    prbs_addr_gen_mc u_dut (
        .clk_i(clk), .rst_i(rst), .seed_load_i(seed_load), .seed_i(seed), .mode_i(mode),
        .addr_rdy_i(rdy), .addr_vld_o(vld), .addr_o(addr), .ch_o(ch)
`ifdef PRBS_LOCKUP_RECOVER_EN
        , .lockup_cnt_o(lockup_cnt)
`endif
    );

    prbs_addr_gen_mc #(
        .NUM_CH(1), .PRBS_WIDTH(8), .ADDR_WIDTH(8), .DWIDTH(8),
        .TAPS(64'hB8), .SADDR(64'h0), .SPAN_MASK(64'hFF)
    ) u_dut8 (
        .clk_i(clk), .rst_i(rst), .seed_load_i(seed_load8), .seed_i(seed8), .mode_i(mode8),
        .addr_rdy_i(rdy8), .addr_vld_o(vld8), .addr_o(addr8), .ch_o(ch8)
`ifdef PRBS_LOCKUP_RECOVER_EN
        , .lockup_cnt_o(lockup_cnt8)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference stream: channel k starts from seed^(k*golden), zero->1, visited round-robin.
    task automatic plan(input logic [31:0] s, input bit seq, input int beats);
        logic [31:0] st[4];
        int          c;
        exp_t        e;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            st[k] = s ^ (32'(k) * 32'h9E37_79B9);
            if (st[k] == 32'd0) st[k] = 32'd1;
        end
        c = 0;
        for (int b = 0; b < beats; b++) begin
            e.ch   = 2'(c);
            e.addr = M_BASE | (st[c] & M_SPAN & ~32'h3);
            exp_q.push_back(e);
            if (seq) st[c] = st[c] + 32'd4;
            else     st[c] = {st[c][30:0], 1'($countones(st[c] & M_TAPS) % 2)};
            c = (c + 1) % 4;
        end
    endtask

    task automatic reseed(input logic [31:0] s, input bit m, input int beats);
        @(posedge clk); #1;
        seed = s; mode = m; seed_load = 1'b1; rdy = 1'b1;
        plan(s, m, beats);
        @(posedge clk); #1;
        seed_load = 1'b0;
    endtask

    task automatic run(input int cycles, input int pat);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            case (pat)
                0:       rdy = 1'($urandom_range(0, 1));
                1:       rdy = 1'b1;
                default: rdy = (i % 4 == 0) || (i % 4 == 3);
            endcase
        end
    endtask

    // Monitor: pops on every accepted beat, checks stall stability and the LOAD bubble.
    logic        p_vld = 1'b0, p_rdy = 1'b0, p_load = 1'b0, p_rst = 1'b1;
    logic [31:0] p_addr = '0;
    logic [1:0]  p_ch = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && !p_rst) begin
            if (p_load) check("load_cycle_vld", 64'(vld), 64'd0);
            if (p_vld && !p_rdy && !p_load) begin
                check("stall_addr", 64'(addr), 64'(p_addr));
                check("stall_ch", 64'(ch), 64'(p_ch));
            end
            if (vld && rdy && !seed_load) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_underflow: beat ch=%0d addr=%0h, expected no beat", ch, addr);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_ch", 64'(ch), 64'(e.ch));
                    check("sb_addr", 64'(addr), 64'(e.addr));
                end
            end
        end
        p_vld = vld; p_rdy = rdy; p_load = seed_load; p_rst = rst;
        p_addr = addr; p_ch = ch;
    end

    initial begin
        logic [7:0] seq8 [5];
        int         period;
        seq8 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld", 64'(vld), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_ch", 64'(ch), 64'd0);
        check("rst_vld8", 64'(vld8), 64'd0);
        check("rst_addr8", 64'(addr8), 64'd0);
        check("rst_ch8", 64'(ch8), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 8-bit maximal LFSR: fixed opening sequence and full period.
        @(posedge clk); #1;
        seed8 = 8'h01; seed_load8 = 1'b1; rdy8 = 1'b1;
        @(posedge clk); #1;
        seed_load8 = 1'b0;
        @(negedge clk);
        check("prbs8_load_vld", 64'(vld8), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("prbs8_vld", 64'(vld8), 64'd1);
            check("prbs8_seq", 64'(addr8), 64'(seq8[i]));
        end
        period = -1;
        for (int j = 5; j < 300 && period < 0; j++) begin
            @(negedge clk);
            if (vld8 && addr8 == 8'h01) period = j;
        end
        check("prbs8_period", 64'(period), 64'd255);
        rdy8 = 1'b0;

        // First load from IDLE: valid two cycles after the seed pulse.
        reseed($urandom, 1'b0, 220);
        @(negedge clk);
        check("first_load_vld", 64'(vld), 64'd0);
        @(negedge clk);
        check("first_vld_latency", 64'(vld), 64'd1);
        check("first_ch", 64'(ch), 64'd0);
        run(200, 0);

        reseed($urandom, 1'b0, 50);
        run(40, 2);

        reseed(32'h00FF_FFF8, 1'b1, 40);
        run(30, 1);

        // Reseed collides with a live handshake (rdy=1, vld=1).
        reseed($urandom, 1'b0, 130);
        run(120, 0);
        reseed(32'd0, 1'b0, 60);
        run(50, 0);
        reseed(32'd0, 1'b1, 60);
        run(50, 0);

        reseed(32'hFFFF_FFFF, 1'b0, 10010);
        run(10000, 1);

`ifdef PRBS_LOCKUP_RECOVER_EN
        reseed($urandom, 1'b0, 40);
        run(20, 0);
        @(posedge clk); #1;
        rdy = 1'b0;
        @(posedge clk); #1;
        u_dut.lfsr_q[0] = '0;
        @(negedge clk);
        check("lockup_vld_low", 64'(vld), 64'd0);
        @(negedge clk);
        check("lockup_lfsr", 64'(u_dut.lfsr_q[0]), 64'd1);
        check("lockup_cnt", 64'(lockup_cnt), 64'd1);
        check("lockup_vld_back", 64'(vld), 64'd1);
`endif

        // Reset mid-stream.
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_vld", 64'(vld), 64'd0);
        check("midrst_addr", 64'(addr), 64'd0);
        check("midrst_ch", 64'(ch), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_stays_invalid", 64'(vld), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
